// File: rtl/bp_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl_pkg
// Shared constants and types for the branch-predictor update controller:
// table geometry, PC width, update-FIFO depth, the value a table entry is
// cleared to, the INIT/RUN state encoding, the queued-update record and the
// saturating add used by the drop counter.
// ---------------------------------------------------------------------------
package bp_update_ctrl_pkg;

    localparam int         BP_ENTRIES     = 1024;
    localparam int         BP_IDX_W       = 10;
    localparam int         PC_W           = 14;
    localparam int         UPD_FIFO_DEPTH = 4;
    localparam logic [1:0] BP_CNT_INIT    = 2'b01;   // weakly not-taken

    localparam int FIFO_PTR_W = $clog2(UPD_FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(UPD_FIFO_DEPTH + 1);
    localparam int DROP_W     = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] pc;
    } upd_entry_t;

    // Adds 0..2 to the drop counter, sticking at all-ones.
    function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                       input logic [1:0]        inc);
        logic [DROP_W:0] sum;
        // NOTE: blocking assignment is correct for function temporaries; every
        // flop in this design is written with <= inside always_ff instead.
        sum = {1'b0, cnt} + {{(DROP_W - 1){1'b0}}, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl_if
// Bundles the two resolved-branch input pipes, the predictor update/clear
// outputs and the status outputs of bp_update_ctrl.
//   master : branch-resolution side (drives br0_*/br1_*, observes the rest)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface bp_update_ctrl_if;
    import bp_update_ctrl_pkg::*;

    logic                br0_valid;
    logic                br0_taken;
    logic [PC_W-1:0]     br0_pc;
    logic                br1_valid;
    logic                br1_taken;
    logic [PC_W-1:0]     br1_pc;
    logic                br_ready;
    logic                upd_valid;
    logic                upd_taken;
    logic [PC_W-1:0]     upd_pc;
    logic                clr_valid;
    logic [BP_IDX_W-1:0] clr_addr;
    logic                init_busy;
    logic [DROP_W-1:0]   drop_cnt;

    modport master (
        output br0_valid, br0_taken, br0_pc, br1_valid, br1_taken, br1_pc,
        input  br_ready, upd_valid, upd_taken, upd_pc, clr_valid, clr_addr,
               init_busy, drop_cnt
    );

    modport slave (
        input  br0_valid, br0_taken, br0_pc, br1_valid, br1_taken, br1_pc,
        output br_ready, upd_valid, upd_taken, upd_pc, clr_valid, clr_addr,
               init_busy, drop_cnt
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// ---------------------------------------------------------------------------
// bp_upd_fifo
// Update queue: two write ports (wr0 lands ahead of wr1 when both fire),
// one read port with the head entry shown combinationally, occupancy output.
//   clk, rstn        : clock, synchronous active-low reset
//   clr              : synchronous clear of all queued entries
//   wr0_en/wr0_data  : first write port
//   wr1_en/wr1_data  : second write port
//   rd_en / rd_data  : pop the head / head entry
//   count            : number of queued entries (0..UPD_FIFO_DEPTH)
// The caller never writes more entries than are free.
// ---------------------------------------------------------------------------
module bp_upd_fifo
    import bp_update_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  wr0_en,
    input  upd_entry_t            wr0_data,
    input  logic                  wr1_en,
    input  upd_entry_t            wr1_data,
    input  logic                  rd_en,
    output upd_entry_t            rd_data,
    output logic [FIFO_CNT_W-1:0] count
);

    upd_entry_t            mem [UPD_FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_PTR_W-1:0] wr1_slot;
    logic [1:0]            n_wr;

    // wr1 goes right behind wr0 when both write, otherwise into the tail slot.
    assign wr1_slot = wr_ptr + FIFO_PTR_W'(wr0_en);
    assign n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign rd_data  = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count define which
    // slots hold valid data, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]   <= wr0_data;
        if (wr1_en) mem[wr1_slot] <= wr1_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + FIFO_PTR_W'(n_wr);     // wraps modulo depth
            if (rd_en) rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
            count  <= count + FIFO_CNT_W'(n_wr) - FIFO_CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
// Serialises resolved branches from two pipes into single-port predictor
// updates, and sweeps the predictor table to BP_CNT_INIT after reset/flush.
//   clk        : clock
//   rstn       : synchronous active-low reset
//   flush      : one-cycle pulse; drops queued updates and restarts the sweep
//   bus.slave  : br0_*/br1_* in, br_ready, upd_*, clr_*, init_busy, drop_cnt
// INIT walks clr_addr 0..BP_ENTRIES-1, one entry per cycle, then enters RUN.
// In RUN one queued update per cycle is registered onto upd_*.
// ---------------------------------------------------------------------------
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    bp_update_ctrl_if.slave bus
);

    localparam logic [BP_IDX_W-1:0]   LAST_IDX  = BP_IDX_W'(BP_ENTRIES - 1);
    // Two free slots needed; a slot freed by this cycle's pop does not count.
    localparam logic [FIFO_CNT_W-1:0] READY_MAX = FIFO_CNT_W'(UPD_FIFO_DEPTH - 2);

    bp_state_e             state;
    logic [BP_IDX_W-1:0]   clr_addr_q;
    logic [DROP_W-1:0]     drop_cnt_q;
    logic                  upd_valid_q;
    upd_entry_t            upd_q;

    logic                  br_ready;
    logic                  deq;
    logic [1:0]            n_drop;
    upd_entry_t            br0_entry;
    upd_entry_t            br1_entry;
    upd_entry_t            fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;

    assign br_ready  = (state == ST_RUN) && (fifo_count <= READY_MAX);
    assign deq       = (state == ST_RUN) && (fifo_count != '0) && !flush;
    assign n_drop    = {1'b0, bus.br0_valid && !br_ready} + {1'b0, bus.br1_valid && !br_ready};
    assign br0_entry = {bus.br0_taken, bus.br0_pc};
    assign br1_entry = {bus.br1_taken, bus.br1_pc};

    bp_upd_fifo u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (flush),
        .wr0_en   (br_ready && bus.br0_valid),
        .wr0_data (br0_entry),
        .wr1_en   (br_ready && bus.br1_valid),
        .wr1_data (br1_entry),
        .rd_en    (deq),
        .rd_data  (fifo_head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_INIT;
            clr_addr_q  <= '0;
            drop_cnt_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_q       <= '0;
        end else begin
            drop_cnt_q <= drop_sat_add(drop_cnt_q, n_drop);
            if (flush) begin
                state       <= ST_INIT;
                clr_addr_q  <= '0;
                upd_valid_q <= 1'b0;
            end else begin
                unique case (state)
                    ST_INIT: begin
                        upd_valid_q <= 1'b0;
                        if (clr_addr_q == LAST_IDX) begin
                            state      <= ST_RUN;
                            clr_addr_q <= '0;
                        end else begin
                            clr_addr_q <= clr_addr_q + BP_IDX_W'(1);
                        end
                    end
                    ST_RUN: begin
                        // upd_taken/upd_pc keep their last value when idle.
                        upd_valid_q <= deq;
                        if (deq) upd_q <= fifo_head;
                    end
                endcase
            end
        end
    end

    assign bus.br_ready  = br_ready;
    assign bus.upd_valid = upd_valid_q;
    assign bus.upd_taken = upd_q.taken;
    assign bus.upd_pc    = upd_q.pc;
    assign bus.clr_valid = (state == ST_INIT);
    assign bus.clr_addr  = clr_addr_q;
    assign bus.init_busy = (state == ST_INIT);
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_update_ctrl
// Directed sequence with randomised branch traffic, checked every cycle
// against a transaction-level reference model (queue of pending updates,
// sweep index, drop total).
// ---------------------------------------------------------------------------
module tb_bp_update_ctrl;
    import bp_update_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic flush;

    bp_update_ctrl_if bus();

    bp_update_ctrl dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    typedef struct {
        bit            taken;
        bit [PC_W-1:0] pc;
    } ref_upd_t;

    ref_upd_t      m_q[$];
    bit            m_init;
    int            m_addr;
    int            m_drops;
    bit            m_uv;
    bit            m_ut;
    bit [PC_W-1:0] m_upc;

    logic [1:0]    tbl [BP_ENTRIES];
    int            clr_seen;
    int            n_cov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return !m_init && (m_q.size() <= UPD_FIFO_DEPTH - 2);
    endfunction

    // Advance the model across one rising edge given this cycle's inputs.
    task automatic model_edge(input bit rn, input bit fl,
                              input bit v0, input bit t0, input bit [PC_W-1:0] p0,
                              input bit v1, input bit t1, input bit [PC_W-1:0] p1);
        bit       ready;
        int       nd;
        ref_upd_t e;
        ready = model_ready();
        if (!rn) begin
            m_init = 1; m_addr = 0; m_q.delete(); m_drops = 0;
            m_uv = 0; m_ut = 0; m_upc = '0;
            return;
        end
        nd = int'(v0 && !ready) + int'(v1 && !ready);
        m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
        if (fl) begin
            m_init = 1; m_addr = 0; m_q.delete(); m_uv = 0;
            return;
        end
        if (m_init) begin
            m_uv = 0;
            if (m_addr == BP_ENTRIES - 1) m_init = 0;
            else m_addr++;
            return;
        end
        if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_uv = 1; m_ut = e.taken; m_upc = e.pc;
        end else begin
            m_uv = 0;
        end
        if (ready && v0) m_q.push_back('{taken: t0, pc: p0});
        if (ready && v1) m_q.push_back('{taken: t1, pc: p1});
    endtask

    task automatic compare_all();
        check("upd_valid", bus.upd_valid, m_uv);
        check("upd_taken", bus.upd_taken, m_ut);
        check("upd_pc",    bus.upd_pc,    m_upc);
        check("init_busy", bus.init_busy, m_init);
        check("clr_valid", bus.clr_valid, m_init);
        if (m_init) check("clr_addr", bus.clr_addr, m_addr);
        check("br_ready",  bus.br_ready,  model_ready());
        check("drop_cnt",  bus.drop_cnt,  m_drops);
    endtask

    // One clock cycle: drive inputs, step the model, sample #1 after the edge.
    task automatic run(input bit rn, input bit fl,
                       input bit v0, input bit t0, input bit [PC_W-1:0] p0,
                       input bit v1, input bit t1, input bit [PC_W-1:0] p1);
        rstn = rn; flush = fl;
        bus.br0_valid = v0; bus.br0_taken = t0; bus.br0_pc = p0;
        bus.br1_valid = v1; bus.br1_taken = t1; bus.br1_pc = p1;
        if (bus.clr_valid === 1'b1) begin
            tbl[bus.clr_addr] = BP_CNT_INIT;
            clr_seen++;
        end
        model_edge(rn, fl, v0, t0, p0, v1, t1, p1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run(1, 0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic rand_run();
        bit v0, v1, t0, t1;
        bit [PC_W-1:0] p0, p1;
        v0 = ($urandom_range(0, 9) < 7);
        v1 = ($urandom_range(0, 9) < 7);
        t0 = 1'($urandom);
        t1 = 1'($urandom);
        p0 = PC_W'($urandom);
        p1 = ($urandom_range(0, 3) == 0) ? p0 : PC_W'($urandom);
        run(1, 0, v0, t0, p0, v1, t1, p1);
    endtask

    initial begin
        rstn = 0; flush = 0;
        bus.br0_valid = 0; bus.br0_taken = 0; bus.br0_pc = '0;
        bus.br1_valid = 0; bus.br1_taken = 0; bus.br1_pc = '0;
        m_init = 1; m_addr = 0; m_drops = 0; m_uv = 0; m_ut = 0; m_upc = '0;
        clr_seen = 0;

        // Reset state
        for (int i = 0; i < 3; i++) run(0, 0, 1, 1, 14'h1111, 1, 0, 14'h2222);
        check("rst_upd_valid", bus.upd_valid, 0);
        check("rst_upd_pc",    bus.upd_pc,    0);
        check("rst_clr_addr",  bus.clr_addr,  0);
        check("rst_drop_cnt",  bus.drop_cnt,  0);
        check("rst_br_ready",  bus.br_ready,  0);
        check("rst_init_busy", bus.init_busy, 1);

        // Full sweep after reset release; early traffic is dropped
        foreach (tbl[i]) tbl[i] = 2'b11;
        clr_seen = 0;
        for (int i = 0; i < 1100 && m_init; i++) begin
            if (i < 20) rand_run();
            else idle(1);
        end
        n_cov = 0;
        foreach (tbl[i]) if (tbl[i] === BP_CNT_INIT) n_cov++;
        check("sweep_len",      clr_seen, BP_ENTRIES);
        check("sweep_cover",    n_cov,    BP_ENTRIES);
        check("sweep_done_busy", bus.init_busy, 0);
        check("sweep_done_rdy",  bus.br_ready,  1);

        // Single update latency
        run(1, 0, 1, 1, 14'h0123, 0, 0, '0);
        check("lat_not_yet", bus.upd_valid, 0);
        idle(1);
        check("lat_valid", bus.upd_valid, 1);
        check("lat_pc",    bus.upd_pc,    14'h0123);
        check("lat_taken", bus.upd_taken, 1);
        idle(1);
        check("lat_one_cycle", bus.upd_valid, 0);

        // Both pipes valid three cycles: backpressure, drops, ordering
        run(1, 0, 1, 0, 14'h0A01, 1, 1, 14'h0B01);
        check("bp_ready_after1", bus.br_ready, 1);
        run(1, 0, 1, 1, 14'h0A02, 1, 0, 14'h0B02);
        check("bp_ready_after2", bus.br_ready, 0);
        run(1, 0, 1, 0, 14'h0A03, 1, 1, 14'h0B03);
        idle(6);

        // Random traffic including identical PCs on both pipes
        for (int i = 0; i < 300; i++) rand_run();
        idle(6);

        // Flush with three entries queued
        run(1, 0, 1, 1, 14'h0C01, 1, 0, 14'h0C02);
        run(1, 0, 1, 0, 14'h0C03, 1, 1, 14'h0C04);
        check("pre_flush_rdy", bus.br_ready, 0);
        run(1, 1, 0, 0, '0, 0, 0, '0);
        check("flush_upd_valid", bus.upd_valid, 0);
        check("flush_clr_addr",  bus.clr_addr,  0);
        check("flush_busy",      bus.init_busy, 1);

        // Flush again mid-sweep at address 10, then a full sweep
        for (int i = 0; i < 1200 && m_init; i++) begin
            if (m_addr == 10 && i < 20) run(1, 1, 0, 0, '0, 0, 0, '0);
            else idle(1);
        end
        check("resweep_done", bus.init_busy, 0);
        idle(2);
        check("post_flush_empty", bus.upd_valid, 0);

        // Reset asserted mid-sweep at address 500
        for (int i = 0; i < 20; i++) rand_run();
        idle(6);
        run(1, 1, 0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 600 && m_addr != 500; i++) begin
            if (i < 10) rand_run();
            else idle(1);
        end
        check("at_500", bus.clr_addr, 500);
        run(0, 0, 0, 0, '0, 0, 0, '0);
        check("rst500_clr_addr", bus.clr_addr, 0);
        check("rst500_drop_cnt", bus.drop_cnt, 0);

        // 300 drops during INIT: saturation at 255
        for (int i = 0; i < 127; i++) run(1, 0, 1, 0, 14'h0001, 1, 1, 14'h0002);
        check("drop_254", bus.drop_cnt, 254);
        for (int i = 0; i < 23; i++) run(1, 0, 1, 0, 14'h0001, 1, 1, 14'h0002);
        check("drop_sat", bus.drop_cnt, 255);

        for (int i = 0; i < 1100 && m_init; i++) idle(1);
        check("final_sweep_done", bus.init_busy, 0);
        for (int i = 0; i < 50; i++) rand_run();
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
